// File: rtl/dct_pkg.sv
// -----------------------------------------------------------------------------
// dct_pkg
//
// Shared definitions for the DCT/IDCT scaling stages:
//   - ERR_NOSOP / ERR_LEN : bit positions inside the 2-bit per-beat error word
//   - PTS_DEFAULT         : frame size assumed after reset
//   - frm_state_t         : frame tracker states
//   - fftpts_to_shift()   : frame size -> left-shift amount S
//   - pts_is_legal()      : true for the supported frame sizes 16..2048
// -----------------------------------------------------------------------------
package dct_pkg;

    localparam int ERR_NOSOP = 0;
    localparam int ERR_LEN   = 1;

    localparam logic [11:0] PTS_DEFAULT = 12'd2048;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } frm_state_t;

    // Two frame sizes share each shift amount. Unsupported sizes fall back to
    // the largest shift, which matches the default 2048-point frame.
    function automatic logic [4:0] fftpts_to_shift(input logic [11:0] pts);
        logic [4:0] s;
        case (pts)
            12'd2048, 12'd1024: s = 5'd16;
            12'd512,  12'd256:  s = 5'd15;
            12'd128,  12'd64:   s = 5'd14;
            12'd32,   12'd16:   s = 5'd13;
            default:            s = 5'd16;
        endcase
        return s;
    endfunction

    function automatic logic pts_is_legal(input logic [11:0] pts);
        logic ok;
        case (pts)
            12'd2048, 12'd1024, 12'd512, 12'd256,
            12'd128,  12'd64,   12'd32,  12'd16: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage : dct_pkg

// File: rtl/idct_frame_checker.sv
// -----------------------------------------------------------------------------
// idct_frame_checker
//
// Tracks frame boundaries on the accepted input stream: latches the frame size
// on every sop beat, counts beats, and flags per-beat errors. Only present in
// builds with IDCT_PRESCALE_FRAMECHK_EN defined.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   accept     in   a beat is transferred this cycle
//   sop        in   current beat is first of frame
//   eop        in   current beat is last of frame
//   fftpts_in  in   frame size offered with the current beat
//   err        out  error flags for the current beat (valid when accept)
//   pts        out  frame size that applies to the current beat
// -----------------------------------------------------------------------------
module idct_frame_checker
    import dct_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        accept,
    input  logic        sop,
    input  logic        eop,
    input  logic [11:0] fftpts_in,
    output logic [1:0]  err,
    output logic [11:0] pts
);

    frm_state_t  state, state_d;
    logic [11:0] count, count_d;
    logic [11:0] pts_q, pts_d;
    logic        sop_is_last;

    // A sop beat is measured against its own size; all others use the latch.
    assign pts = sop ? fftpts_in : pts_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            pts_q <= PTS_DEFAULT;
        end else begin
            state <= state_d;
            count <= count_d;
            pts_q <= pts_d;
        end
    end

    // NOTE: every variable driven here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d     = state;
        count_d     = count;
        pts_d       = pts_q;
        err         = 2'b00;
        sop_is_last = 1'b0;

        if (accept) begin
            if (sop) begin
                // A sop always (re)starts a frame. A sop seen mid-frame is a
                // length error on the interrupted frame, reported on this beat.
                sop_is_last  = (fftpts_in == 12'd1);
                pts_d        = fftpts_in;
                count_d      = 12'd1;
                err[ERR_LEN] = !pts_is_legal(fftpts_in)
                               || (eop != sop_is_last)
                               || (state == BUSY);
                state_d      = (eop || sop_is_last) ? IDLE : BUSY;
            end else if (state == IDLE) begin
                err[ERR_NOSOP] = 1'b1;
            end else if (count == pts_q - 12'd1) begin
                // Final beat by count: missing eop is an implicit end.
                err[ERR_LEN] = !eop;
                state_d      = IDLE;
                count_d      = '0;
            end else if (eop) begin
                err[ERR_LEN] = 1'b1;
                state_d      = IDLE;
                count_d      = '0;
            end else begin
                count_d = count + 12'd1;
            end
        end
    end

endmodule : idct_frame_checker

// File: rtl/idct_prescaling.sv
// -----------------------------------------------------------------------------
// idct_prescaling
//
// Input-side scaler for the IDCT path. Sign-extends each complex sample from
// wDataIn to wDataOut bits and left-shifts it by a frame-size-dependent amount
// (13..16), undoing the output stage's scaling. One register stage with
// ready/valid backpressure; sink_ready is the only combinational path.
//
// Build option: IDCT_PRESCALE_FRAMECHK_EN
//   defined   - idct_frame_checker tracks frames and drives source_error
//   undefined - no frame checking, source_error is always 2'b00, a beat
//               without sop uses the last latched frame size
//
// Parameters:
//   wDataIn   input sample width (two's complement), default 24
//   wDataOut  output sample width, must be >= wDataIn+16, default 48
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   sink_valid    in   input beat valid
//   sink_ready    out  block can accept a beat
//   sink_sop      in   first beat of frame
//   sink_eop      in   last beat of frame
//   sink_real     in   real sample
//   sink_imag     in   imaginary sample
//   fftpts_in     in   frame size, taken on an accepted sop beat
//   source_valid  out  output beat valid
//   source_ready  in   downstream accepts
//   source_sop    out  sop aligned with data
//   source_eop    out  eop aligned with data
//   source_real   out  scaled real sample
//   source_imag   out  scaled imaginary sample
//   source_error  out  bit0 missing sop, bit1 length error
//   fftpts_out    out  frame size that applies to the output beat
// -----------------------------------------------------------------------------
module idct_prescaling
    import dct_pkg::*;
#(
    parameter int wDataIn  = 24,
    parameter int wDataOut = 48
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sink_valid,
    output logic                sink_ready,
    input  logic                sink_sop,
    input  logic                sink_eop,
    input  logic [wDataIn-1:0]  sink_real,
    input  logic [wDataIn-1:0]  sink_imag,
    input  logic [11:0]         fftpts_in,
    output logic                source_valid,
    input  logic                source_ready,
    output logic                source_sop,
    output logic                source_eop,
    output logic [wDataOut-1:0] source_real,
    output logic [wDataOut-1:0] source_imag,
    output logic [1:0]          source_error,
    output logic [11:0]         fftpts_out
);

    localparam int EXT = wDataOut - wDataIn;

    logic                accept;
    logic [1:0]          beat_err;
    logic [11:0]         beat_pts;
    logic [4:0]          beat_shift;
    logic [wDataOut-1:0] real_ext;
    logic [wDataOut-1:0] imag_ext;
    logic [wDataOut-1:0] real_scaled;
    logic [wDataOut-1:0] imag_scaled;

    // The register may load whenever it is empty or being drained this cycle.
    assign sink_ready = !source_valid || source_ready;
    assign accept     = sink_valid && sink_ready;

`ifdef IDCT_PRESCALE_FRAMECHK_EN
    idct_frame_checker u_frame_checker (
        .clk       (clk),
        .rst       (rst),
        .accept    (accept),
        .sop       (sink_sop),
        .eop       (sink_eop),
        .fftpts_in (fftpts_in),
        .err       (beat_err),
        .pts       (beat_pts)
    );

    // A beat outside any frame has no trustworthy size, so it gets the
    // default shift rather than the stale latched one.
    assign beat_shift = beat_err[ERR_NOSOP] ? 5'd16 : fftpts_to_shift(beat_pts);
`else
    logic [11:0] pts_latched;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pts_latched <= PTS_DEFAULT;
        end else if (accept && sink_sop) begin
            pts_latched <= fftpts_in;
        end
    end

    assign beat_pts   = sink_sop ? fftpts_in : pts_latched;
    assign beat_err   = 2'b00;
    assign beat_shift = fftpts_to_shift(beat_pts);
`endif

    // Exact scaling: with EXT >= 16 and S <= 16 no significant bit is lost.
    assign real_ext    = {{EXT{sink_real[wDataIn-1]}}, sink_real};
    assign imag_ext    = {{EXT{sink_imag[wDataIn-1]}}, sink_imag};
    assign real_scaled = real_ext << beat_shift;
    assign imag_scaled = imag_ext << beat_shift;

    // NOTE: the datapath registers are reset too, so every output reads a
    // defined value (zero) while reset is held, not just source_valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            source_valid <= 1'b0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_real  <= '0;
            source_imag  <= '0;
            source_error <= 2'b00;
            fftpts_out   <= PTS_DEFAULT;
        end else if (accept) begin
            source_valid <= 1'b1;
            source_sop   <= sink_sop;
            source_eop   <= sink_eop;
            source_real  <= real_scaled;
            source_imag  <= imag_scaled;
            source_error <= beat_err;
            fftpts_out   <= beat_pts;
        end else if (source_ready) begin
            // Payload is left as-is; it is only meaningful with source_valid.
            source_valid <= 1'b0;
        end
    end

endmodule : idct_prescaling

// File: tb/tb_idct_prescaling.sv
// -----------------------------------------------------------------------------
// tb_idct_prescaling
//
// Self-checking bench for idct_prescaling. A frame-level reference model turns
// every accepted input beat into an expected output beat (queue); a monitor on
// the falling edge compares the DUT output register, valid and ready against
// that queue. Honours IDCT_PRESCALE_FRAMECHK_EN to select expected errors.
// -----------------------------------------------------------------------------
module tb_idct_prescaling;

`ifdef IDCT_PRESCALE_FRAMECHK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        sink_valid;
    logic        sink_ready;
    logic        sink_sop;
    logic        sink_eop;
    logic [23:0] sink_real;
    logic [23:0] sink_imag;
    logic [11:0] fftpts_in;
    logic        source_valid;
    logic        source_ready;
    logic        source_sop;
    logic        source_eop;
    logic [47:0] source_real;
    logic [47:0] source_imag;
    logic [1:0]  source_error;
    logic [11:0] fftpts_out;

    idct_prescaling #(.wDataIn(24), .wDataOut(48)) dut (
        .clk          (clk),
        .rst          (rst),
        .sink_valid   (sink_valid),
        .sink_ready   (sink_ready),
        .sink_sop     (sink_sop),
        .sink_eop     (sink_eop),
        .sink_real    (sink_real),
        .sink_imag    (sink_imag),
        .fftpts_in    (fftpts_in),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_sop   (source_sop),
        .source_eop   (source_eop),
        .source_real  (source_real),
        .source_imag  (source_imag),
        .source_error (source_error),
        .fftpts_out   (fftpts_out)
    );

    typedef struct {
        logic        sop;
        logic        eop;
        logic [47:0] re;
        logic [47:0] im;
        logic [1:0]  err;
        logic [11:0] pts;
    } exp_t;

    exp_t q[$];

    int  n_checks = 0;
    int  n_fails  = 0;
    int  bp_mode  = 0;     // 0: always ready, 1: 1,0,0,1 pattern, 2: random
    bit  mon_en   = 1'b0;
    time t_first, t_last;

    // Reference model state: frame size in force, inside-frame flag, beats seen.
    int  m_pts   = 2048;
    bit  m_busy  = 1'b0;
    int  m_count = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit legal(input int pts);
        return (pts >= 16) && (pts <= 2048) && ((pts & (pts - 1)) == 0);
    endfunction

    // Each pair of sizes (16/32, 64/128, ...) raises the shift by one.
    function automatic int shift_of(input int pts);
        if (!legal(pts)) return 16;
        return 11 + $clog2(pts) / 2;
    endfunction

    function automatic logic [47:0] scale(input logic [23:0] x, input int s);
        longint v;
        v = longint'($signed(x)) * (longint'(1) << s);
        return v[47:0];
    endfunction

    task automatic model_beat(input bit sop, input bit eop, input int pts_in,
                              input logic [23:0] re, input logic [23:0] im);
        exp_t e;
        int   s;
        e.err = 2'b00;
        if (sop) begin
            e.pts    = 12'(pts_in);
            s        = shift_of(pts_in);
            e.err[1] = !legal(pts_in) || (eop != (pts_in == 1)) || m_busy;
            m_busy   = !(eop || pts_in == 1);
            m_count  = 1;
            m_pts    = pts_in;
        end else if (!m_busy) begin
            e.pts    = 12'(m_pts);
            e.err[0] = 1'b1;
            s        = CHK_EN ? 16 : shift_of(m_pts);
        end else begin
            e.pts = 12'(m_pts);
            s     = shift_of(m_pts);
            if (m_count == m_pts - 1) begin
                e.err[1] = !eop;
                m_busy   = 1'b0;
            end else if (eop) begin
                e.err[1] = 1'b1;
                m_busy   = 1'b0;
            end else begin
                m_count++;
            end
        end
        if (!CHK_EN) e.err = 2'b00;
        e.sop = sop;
        e.eop = eop;
        e.re  = scale(re, s);
        e.im  = scale(im, s);
        q.push_back(e);
    endtask

    // Downstream ready generator, updated just after each rising edge.
    initial begin
        int ph = 0;
        source_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                1: begin
                    source_ready = (ph == 0) || (ph == 3);
                    ph = (ph + 1) % 4;
                end
                2:       source_ready = ($urandom_range(0, 3) != 0);
                default: source_ready = 1'b1;
            endcase
        end
    end

    // Output monitor: the head of the queue is what the register must hold.
    initial begin
        exp_t f;
        forever begin
            @(negedge clk);
            if (!rst && mon_en) begin
                check("sink_ready", 64'(sink_ready), 64'(!(q.size() > 0 && !source_ready)));
                check("source_valid", 64'(source_valid), 64'(q.size() > 0));
                if (source_valid && q.size() > 0) begin
                    f = q[0];
                    check("source_sop",   64'(source_sop),   64'(f.sop));
                    check("source_eop",   64'(source_eop),   64'(f.eop));
                    check("source_real",  64'(source_real),  64'(f.re));
                    check("source_imag",  64'(source_imag),  64'(f.im));
                    check("source_error", 64'(source_error), 64'(f.err));
                    check("fftpts_out",   64'(fftpts_out),   64'(f.pts));
                    if (source_ready) void'(q.pop_front());
                end
            end
        end
    end

    // Offer one beat and hold it until accepted; returns just after the edge.
    task automatic send_beat(input bit sop, input bit eop, input int pts,
                             input logic [23:0] re, input logic [23:0] im);
        int waited = 0;
        sink_valid = 1'b1;
        sink_sop   = sop;
        sink_eop   = eop;
        sink_real  = re;
        sink_imag  = im;
        fftpts_in  = 12'(pts);
        @(negedge clk);
        while (!sink_ready && waited < 200) begin
            waited++;
            @(negedge clk);
        end
        if (!sink_ready) begin
            check("accept_timeout", 64'(sink_ready), 64'd1);
        end else begin
            @(posedge clk);
            model_beat(sop, eop, pts, re, im);
            t_last = $time;
            #1;
        end
    endtask

    task automatic idle(input int n);
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // nbeats beats; eop on beat eop_at (1-based, 0 = never).
    task automatic send_frame(input int pts, input int nbeats, input int eop_at,
                              input bit fixed, input logic [23:0] fre);
        for (int i = 1; i <= nbeats; i++) begin
            send_beat(i == 1, i == eop_at, pts,
                      fixed ? fre : 24'($urandom), 24'($urandom));
            if (i == 1) t_first = t_last;
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        q.delete();
        m_pts  = 2048;
        m_busy = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(source_valid), 64'd0);
        check("rst_sop",   64'(source_sop),   64'd0);
        check("rst_eop",   64'(source_eop),   64'd0);
        check("rst_real",  64'(source_real),  64'd0);
        check("rst_imag",  64'(source_imag),  64'd0);
        check("rst_error", 64'(source_error), 64'd0);
        check("rst_pts",   64'(fftpts_out),   64'd2048);
        check("rst_ready", 64'(sink_ready),   64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int drain;
        int pts_r;
        sink_valid = 1'b0;
        sink_sop   = 1'b0;
        sink_eop   = 1'b0;
        sink_real  = '0;
        sink_imag  = '0;
        fftpts_in  = 12'd2048;
        rst        = 1'b1;
        #2;
        do_reset();
        mon_en = 1'b1;

        // Stray beat after reset, then a sop with an unsupported size.
        send_beat(1'b0, 1'b0, 512, 24'h000123, 24'hFFFFFE);
        send_beat(1'b1, 1'b1, 100, 24'h7FFFFF, 24'h800001);
        idle(3);

        // Full 2048-point frame at one beat per cycle.
        bp_mode = 0;
        send_frame(2048, 2048, 2048, 1'b1, 24'h000001);
        check("throughput_2048", 64'(t_last - t_first), 64'(2047 * 10));
        idle(3);

        // Most negative input at the smallest size.
        send_frame(16, 16, 16, 1'b1, 24'h800000);
        idle(3);

        // Backpressure pattern across a 64-point frame.
        bp_mode = 1;
        send_frame(64, 64, 64, 1'b0, 24'h0);
        idle(4);
        bp_mode = 0;
        idle(2);

        // Early eop, then a clean frame.
        send_frame(32, 20, 20, 1'b0, 24'h0);
        send_frame(32, 32, 32, 1'b0, 24'h0);
        idle(2);

        // Implicit end at count, then a stray beat outside any frame.
        send_frame(16, 16, 0, 1'b0, 24'h0);
        send_beat(1'b0, 1'b0, 16, 24'($urandom), 24'($urandom));
        idle(2);

        // Sop arriving mid-frame restarts the frame.
        send_frame(64, 5, 0, 1'b0, 24'h0);
        send_frame(32, 32, 32, 1'b0, 24'h0);
        idle(2);

        // Random sizes and data under random backpressure.
        bp_mode = 2;
        for (int k = 0; k < 6; k++) begin
            pts_r = 16 << $urandom_range(0, 4);
            send_frame(pts_r, pts_r, pts_r, 1'b0, 24'h0);
        end
        idle(4);
        bp_mode = 0;
        idle(2);

        // Reset at beat 10 of a 256-point frame, then a clean full frame.
        send_frame(256, 10, 0, 1'b0, 24'h0);
        do_reset();
        send_frame(256, 256, 256, 1'b0, 24'h0);
        idle(2);

        drain = 0;
        while (q.size() > 0 && drain < 50) begin
            drain++;
            @(posedge clk);
        end
        @(negedge clk);
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule : tb_idct_prescaling
